// File: rtl/planta_pkg.sv
// Shared definitions for the bottling-line plant emulator: FSM states,
// default timing constants and verdict LFSR constants.
package planta_pkg;

    typedef enum logic [3:0] {
        IDLE,
        TRANSPORTE,
        POSICIONADA,
        ENCHENDO,
        CHEIA,
        INSPECAO,
        RESULTADO,
        DESCARTE,
        FIM
    } estado_t;

    localparam int T_TRANSPORTE_DEF    = 8;
    localparam int T_ENCHER_DEF        = 5;
    localparam int T_INSPECAO_DEF      = 3;
    localparam int T_DESCARTE_MAX_DEF  = 15;
    localparam int RECARGA_PERIODO_DEF = 4;
    localparam int RECARGA_QTD_DEF     = 10;

    localparam logic [7:0] PADRAO_QUALIDADE_DEF = 8'b1110_1101;

    // x^8+x^6+x^5+x^4+1 expressed as the register bits feeding the XOR
    localparam logic [7:0] LFSR_SEED = 8'hA5;
    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    // Bits needed for a counter that runs 0..n-1 (at least one bit)
    function automatic int largura(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    function automatic logic [7:0] lfsr_avanca(input logic [7:0] q);
        return {q[6:0], ^(q & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/planta_engarrafamento_if.sv
// Sensor/actuator bundle between the line controller (master) and the
// plant emulator (slave).
interface planta_engarrafamento_if;

    logic       habilitar;
    logic       motor;
    logic       led_enchendo;
    logic       led_descartou;
    logic       led_erro;

    logic       start;
    logic       garrafa;
    logic       sensorev;
    logic       aprovada;
    logic       reprovada;
    logic       incrementar;
    logic [7:0] contador_garrafas;
    logic       falha_descarte;

    modport slave (
        input  habilitar, motor, led_enchendo, led_descartou, led_erro,
        output start, garrafa, sensorev, aprovada, reprovada, incrementar,
               contador_garrafas, falha_descarte
    );

    modport master (
        output habilitar, motor, led_enchendo, led_descartou, led_erro,
        input  start, garrafa, sensorev, aprovada, reprovada, incrementar,
               contador_garrafas, falha_descarte
    );

endinterface

// File: rtl/recarga_rolhas.sv
// Cork refill engine: on each rising edge of led_erro, emits up to QTD
// one-cycle incrementar pulses spaced PERIODO cycles apart.
module recarga_rolhas
    import planta_pkg::*;
#(
    parameter int PERIODO = RECARGA_PERIODO_DEF,
    parameter int QTD     = RECARGA_QTD_DEF
) (
    input  logic clk,
    input  logic reset,
    input  logic led_erro,
    output logic incrementar
);

    localparam int PER_W = largura(PERIODO);
    localparam int QTD_W = largura(QTD);
    localparam logic [PER_W-1:0] PER_FIM = PER_W'(PERIODO - 1);
    localparam logic [QTD_W-1:0] QTD_FIM = QTD_W'(QTD - 1);

    logic             erro_d;
    logic             ativo;
    logic [PER_W-1:0] per;
    logic [QTD_W-1:0] qtd;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            erro_d      <= 1'b0;
            ativo       <= 1'b0;
            per         <= '0;
            qtd         <= '0;
            incrementar <= 1'b0;
        end else begin
            erro_d      <= led_erro;
            incrementar <= 1'b0;
            // A fresh rising edge always restarts with a full budget
            if (led_erro && !erro_d) begin
                ativo <= 1'b1;
                per   <= '0;
                qtd   <= '0;
            end else if (ativo) begin
                if (!led_erro) begin
                    ativo <= 1'b0;
                end else if (per == PER_FIM) begin
                    per         <= '0;
                    incrementar <= 1'b1;
                    if (qtd == QTD_FIM) begin
                        ativo <= 1'b0;
                    end else begin
                        qtd <= qtd + 1'b1;
                    end
                end else begin
                    per <= per + 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/planta_engarrafamento.sv
// Bottling-line plant emulator: answers the controller's actuators with
// bottle, level, verdict and refill signals. Define PLANTA_ALEATORIO_EN for LFSR verdicts.
module planta_engarrafamento
    import planta_pkg::*;
#(
    parameter int         T_TRANSPORTE     = T_TRANSPORTE_DEF,
    parameter int         T_ENCHER         = T_ENCHER_DEF,
    parameter int         T_INSPECAO       = T_INSPECAO_DEF,
    parameter int         T_DESCARTE_MAX   = T_DESCARTE_MAX_DEF,
    parameter logic [7:0] PADRAO_QUALIDADE = PADRAO_QUALIDADE_DEF,
    parameter int         RECARGA_PERIODO  = RECARGA_PERIODO_DEF,
    parameter int         RECARGA_QTD      = RECARGA_QTD_DEF
) (
    input logic                     clk,
    input logic                     reset,
    planta_engarrafamento_if.slave  bus
);

    localparam int POS_W   = largura(T_TRANSPORTE);
    localparam int NIVEL_W = largura(T_ENCHER);
    localparam int INSP_W  = largura(T_INSPECAO);
    localparam int DESC_W  = largura(T_DESCARTE_MAX);

    localparam logic [POS_W-1:0]   POS_FIM   = POS_W'(T_TRANSPORTE - 1);
    localparam logic [NIVEL_W-1:0] NIVEL_FIM = NIVEL_W'(T_ENCHER - 1);
    localparam logic [INSP_W-1:0]  INSP_FIM  = INSP_W'(T_INSPECAO - 1);
    localparam logic [DESC_W-1:0]  DESC_FIM  = DESC_W'(T_DESCARTE_MAX - 1);

`ifdef PLANTA_ALEATORIO_EN
    localparam logic [7:0] PADRAO_INICIAL = LFSR_SEED;

    function automatic logic [7:0] proximo_padrao(input logic [7:0] p);
        return lfsr_avanca(p);
    endfunction
`else
    localparam logic [7:0] PADRAO_INICIAL = PADRAO_QUALIDADE;

    function automatic logic [7:0] proximo_padrao(input logic [7:0] p);
        return {p[0], p[7:1]};
    endfunction
`endif

    estado_t              estado, estado_n;
    logic [POS_W-1:0]     pos, pos_n;
    logic [NIVEL_W-1:0]   nivel, nivel_n;
    logic [INSP_W-1:0]    insp, insp_n;
    logic [DESC_W-1:0]    desc, desc_n;
    logic [7:0]           padrao, padrao_n;
    logic [7:0]           contador, contador_n;
    logic                 start_r, start_n;
    logic                 garrafa_r, garrafa_n;
    logic                 sensorev_r, sensorev_n;
    logic                 aprovada_r, aprovada_n;
    logic                 reprovada_r, reprovada_n;
    logic                 falha_r, falha_n;
    logic                 incrementar;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado      <= IDLE;
            pos         <= '0;
            nivel       <= '0;
            insp        <= '0;
            desc        <= '0;
            padrao      <= PADRAO_INICIAL;
            contador    <= '0;
            start_r     <= 1'b0;
            garrafa_r   <= 1'b0;
            sensorev_r  <= 1'b0;
            aprovada_r  <= 1'b0;
            reprovada_r <= 1'b0;
            falha_r     <= 1'b0;
        end else begin
            estado      <= estado_n;
            pos         <= pos_n;
            nivel       <= nivel_n;
            insp        <= insp_n;
            desc        <= desc_n;
            padrao      <= padrao_n;
            contador    <= contador_n;
            start_r     <= start_n;
            garrafa_r   <= garrafa_n;
            sensorev_r  <= sensorev_n;
            aprovada_r  <= aprovada_n;
            reprovada_r <= reprovada_n;
            falha_r     <= falha_n;
        end
    end

    always_comb begin
        estado_n    = estado;
        pos_n       = pos;
        nivel_n     = nivel;
        insp_n      = insp;
        desc_n      = desc;
        padrao_n    = padrao;
        contador_n  = contador;
        start_n     = 1'b0;
        garrafa_n   = garrafa_r;
        sensorev_n  = sensorev_r;
        aprovada_n  = 1'b0;
        reprovada_n = 1'b0;
        falha_n     = falha_r;

        case (estado)
            IDLE: begin
                if (bus.habilitar) begin
                    start_n  = 1'b1;
                    estado_n = TRANSPORTE;
                end
            end
            TRANSPORTE: begin
                if (bus.motor) begin
                    if (pos == POS_FIM) begin
                        pos_n     = '0;
                        garrafa_n = 1'b1;
                        estado_n  = POSICIONADA;
                    end else begin
                        pos_n = pos + 1'b1;
                    end
                end
            end
            // The cycle that opens the valve already counts as filling
            POSICIONADA: begin
                if (bus.led_enchendo) begin
                    if (T_ENCHER == 1) begin
                        sensorev_n = 1'b1;
                        estado_n   = CHEIA;
                    end else begin
                        nivel_n  = NIVEL_W'(1);
                        estado_n = ENCHENDO;
                    end
                end
            end
            ENCHENDO: begin
                if (bus.led_enchendo) begin
                    if (nivel == NIVEL_FIM) begin
                        nivel_n    = '0;
                        sensorev_n = 1'b1;
                        estado_n   = CHEIA;
                    end else begin
                        nivel_n = nivel + 1'b1;
                    end
                end
            end
            CHEIA: begin
                if (bus.motor) begin
                    garrafa_n  = 1'b0;
                    sensorev_n = 1'b0;
                    estado_n   = INSPECAO;
                end
            end
            // Verdict is registered here so the pulse coincides with RESULTADO
            INSPECAO: begin
                if (insp == INSP_FIM) begin
                    insp_n      = '0;
                    aprovada_n  = padrao[0];
                    reprovada_n = ~padrao[0];
                    estado_n    = RESULTADO;
                end else begin
                    insp_n = insp + 1'b1;
                end
            end
            RESULTADO: begin
                padrao_n = proximo_padrao(padrao);
                if (aprovada_r) begin
                    contador_n = contador + 8'd1;
                    estado_n   = FIM;
                end else begin
                    estado_n = DESCARTE;
                end
            end
            DESCARTE: begin
                if (bus.led_descartou) begin
                    desc_n   = '0;
                    estado_n = FIM;
                end else if (desc == DESC_FIM) begin
                    desc_n   = '0;
                    falha_n  = 1'b1;
                    estado_n = FIM;
                end else begin
                    desc_n = desc + 1'b1;
                end
            end
            FIM: begin
                estado_n = bus.habilitar ? TRANSPORTE : IDLE;
            end
            default: begin
                estado_n = IDLE;
            end
        endcase
    end

    recarga_rolhas #(
        .PERIODO (RECARGA_PERIODO),
        .QTD     (RECARGA_QTD)
    ) u_recarga (
        .clk         (clk),
        .reset       (reset),
        .led_erro    (bus.led_erro),
        .incrementar (incrementar)
    );

    assign bus.start             = start_r;
    assign bus.garrafa           = garrafa_r;
    assign bus.sensorev          = sensorev_r;
    assign bus.aprovada          = aprovada_r;
    assign bus.reprovada         = reprovada_r;
    assign bus.incrementar       = incrementar;
    assign bus.contador_garrafas = contador;
    assign bus.falha_descarte    = falha_r;

endmodule

// File: doc/planta_engarrafamento.md
Name: planta_engarrafamento

Overview:
- Synthesizable bottling-line plant emulator: the plant side of the line controller's sensor/actuator interface.
- Consumes the controller's actuator outputs (motor, filling LED, discard LED, error LED).
- Produces the sensor and operator signals the controller expects: bottle present, level sensor, quality approve/reject, start pulse, cork refill pulses.
- Used for FPGA demos and closed-loop verification of the controller; runs on the same divided clock as the controller.

Parameters:
- T_TRANSPORTE, 8, motor-on cycles needed to bring a bottle under the filler (>=1).
- T_ENCHER, 5, cycles with led_enchendo=1 until the level sensor trips (>=1).
- T_INSPECAO, 3, cycles between the bottle leaving the filler and the quality verdict (>=1).
- T_DESCARTE_MAX, 15, cycles to wait for led_descartou after a reject.
- PADRAO_QUALIDADE, 8'b1110_1101, verdict pattern; bit 0 is used first; 1 = approve.
- RECARGA_PERIODO, 4, cycles between refill pulses while led_erro=1 (>=1).
- RECARGA_QTD, 10, maximum refill pulses per led_erro episode.

Ports:
- clk, in, 1, system clock (divided clock domain).
- reset, in, 1, asynchronous, active-low reset.
- habilitar, in, 1, plant run enable.
- motor, in, 1, conveyor motor command from the controller.
- led_enchendo, in, 1, filling valve active.
- led_descartou, in, 1, controller discarding a rejected bottle.
- led_erro, in, 1, controller reports no corks available.
- start, out, 1, one-cycle operator start pulse.
- garrafa, out, 1, bottle present at the filler.
- sensorev, out, 1, bottle-full level sensor.
- aprovada, out, 1, one-cycle quality-approve pulse.
- reprovada, out, 1, one-cycle quality-reject pulse.
- incrementar, out, 1, one-cycle cork-refill pulse.
- contador_garrafas, out, 8, approved bottle count (wraps 255->0).
- falha_descarte, out, 1, sticky flag: discard timeout occurred.

Behaviour:
- Reset (reset=0, asynchronous):
  - State IDLE; all outputs 0; all counters 0.
  - Pattern register loaded with PADRAO_QUALIDADE.
  - Applies immediately and mid-operation; any verdict or refill in progress is abandoned.
- IDLE: on habilitar=1, pulse start for 1 cycle and enter TRANSPORTE.
- TRANSPORTE:
  - pos counter increments only on cycles with motor=1 and holds while motor=0.
  - When pos reaches T_TRANSPORTE-1 with motor=1: clear pos, set garrafa=1 (registered, visible the next cycle), enter POSICIONADA.
- POSICIONADA: garrafa=1; led_enchendo=1 enters ENCHENDO.
- ENCHENDO:
  - nivel counter increments on cycles with led_enchendo=1 and holds otherwise.
  - When nivel reaches T_ENCHER-1: set sensorev=1, enter CHEIA.
- CHEIA:
  - garrafa=1 and sensorev=1 held.
  - motor=1 clears both the next cycle and enters INSPECAO.
- INSPECAO: wait exactly T_INSPECAO cycles, then enter RESULTADO.
- RESULTADO (1 cycle):
  - Pulse aprovada if pattern[0]=1, else pulse reprovada; never both.
  - Pattern rotates right by 1.
  - Approve: contador_garrafas +1, then go to FIM.
  - Reject: go to DESCARTE.
- DESCARTE:
  - Wait for led_descartou=1, then go to FIM.
  - After T_DESCARTE_MAX cycles without it: set falha_descarte (cleared only by reset), then go to FIM.
- FIM: habilitar=1 goes to TRANSPORTE without a new start pulse; habilitar=0 goes to IDLE.
- habilitar deasserting mid-bottle does not abort; the current bottle completes to FIM.
- Refill engine (independent of the main FSM):
  - Armed when led_erro rises: pulse incrementar once every RECARGA_PERIODO cycles, up to RECARGA_QTD pulses.
  - Stops early when led_erro falls.
  - A new rising edge of led_erro re-arms it with a fresh count.
- Counter wrap: contador_garrafas goes 255 -> 0 with no flag.

Optional Feature:
- Macro PLANTA_ALEATORIO_EN.
- Defined:
  - Verdict comes from an 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, seed 8'hA5 on reset.
  - Approve when lfsr[0]=1; the LFSR advances once per RESULTADO.
  - PADRAO_QUALIDADE is ignored.
- Undefined: fixed rotating pattern as above.
- Timing is identical in both cases.

Decomposition:
- Package planta_pkg holds:
  - The state enumeration: IDLE, TRANSPORTE, POSICIONADA, ENCHENDO, CHEIA, INSPECAO, RESULTADO, DESCARTE, FIM.
  - Default timing constants.
  - LFSR seed and taps.
- One sub-module: recarga_rolhas (refill pulse engine with edge detect, period counter and pulse counter).

Test Plan:
- Reset, then habilitar=1, motor=1 constant -> start pulse at cycle 1; garrafa=1 after 8 motor cycles; sensorev=1 after 5 led_enchendo cycles.
- Motor toggles 1/0 each cycle during transport -> garrafa rises after 8 motor-high cycles (~16 clocks), not 8.
- Eight bottles with default pattern -> verdicts in order A,R,A,A,R,A,A,A; contador_garrafas=6.
- Reject with led_descartou never asserted -> FIM after 15 cycles, falha_descarte=1 and sticky until reset.
- led_erro=1 held for 60 cycles -> exactly 10 incrementar pulses spaced 4 cycles apart; lower then raise led_erro -> counting restarts.
- reset pulled low during CHEIA -> garrafa, sensorev and all outputs 0 asynchronously; state IDLE; pattern reloaded so the next verdict is A.
